// File: rtl/pu_pkg.sv
// Shared constants and types for the processor register-array write path.
package pu_pkg;
   localparam int WIDTH   = 15;
   localparam int RASB    = 1;
   localparam int NREG    = 4;
   localparam int REQ_ALU = 0;
   localparam int REQ_LD  = 1;

   typedef struct packed {
      logic [RASB:0]  ad;
      logic [WIDTH:0] d;
   } wreq_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; same-address conflicts go to the older slot
// so writes to one register keep their arrival order.
module rr_arb2
   import pu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       same_ad,
   input  logic       pri,
   input  logic       old,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01: gnt[REQ_ALU] = 1'b1;
         2'b10: gnt[REQ_LD]  = 1'b1;
         2'b11: begin
            if (same_ad ? old : pri) gnt[REQ_LD]  = 1'b1;
            else                     gnt[REQ_ALU] = 1'b1;
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/rega_wrarb.sv
// Write-port arbiter for the 2R/1W register array: two one-entry holding
// slots drain through a round-robin grant into registered we/wad/wd.
module rega_wrarb #(
   parameter int WIDTH = pu_pkg::WIDTH,
   parameter int RASB  = pu_pkg::RASB,
   parameter int NREG  = pu_pkg::NREG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             v0,
   output logic             rdy0,
   input  logic [RASB:0]    ad0,
   input  logic [WIDTH:0]   d0,
   input  logic             v1,
   output logic             rdy1,
   input  logic [RASB:0]    ad1,
   input  logic [WIDTH:0]   d1,
   output logic             we,
   output logic [RASB:0]    wad,
   output logic [WIDTH:0]   wd,
   output logic [NREG-1:0]  pend
);
   import pu_pkg::*;

   localparam int AW = RASB + 1;

   logic [1:0]      slot_v;
   logic [RASB:0]   slot_ad [2];
   logic [WIDTH:0]  slot_d  [2];
   logic            pri;
   logic            old;
   logic            old_nxt;
   logic [1:0]      gnt;
   logic [1:0]      rdy;
   logic [1:0]      vin;
   logic [1:0]      acc;
   logic [1:0]      nxt_v;
   logic [1:0]      kept;
   logic            gk;
   logic [RASB:0]   in_ad [2];
   logic [WIDTH:0]  in_d  [2];

   assign vin           = {v1, v0};
   assign in_ad[REQ_ALU] = ad0;
   assign in_ad[REQ_LD]  = ad1;
   assign in_d[REQ_ALU]  = d0;
   assign in_d[REQ_LD]   = d1;

   rr_arb2 u_arb (
      .req     (slot_v),
      .same_ad (slot_ad[0] == slot_ad[1]),
      .pri     (pri),
      .old     (old),
      .gnt     (gnt)
   );

   // A granted slot may refill on the edge it drains.
   assign rdy   = ~slot_v | gnt;
   assign rdy0  = rdy[REQ_ALU];
   assign rdy1  = rdy[REQ_LD];
   assign acc   = vin & rdy;
   assign kept  = slot_v & ~gnt;
   assign nxt_v = acc | kept;
   assign gk    = gnt[REQ_LD];

   // A slot held over from an earlier edge is older than a fresh fill; two
   // fills on the same edge count requester 0 as older.
   always_comb begin
      old_nxt = old;
      case (nxt_v)
         2'b01: old_nxt = 1'b0;
         2'b10: old_nxt = 1'b1;
         2'b11: old_nxt = kept[1] & ~kept[0];
         default: old_nxt = old;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_v <= 2'b00;
         pri    <= 1'b0;
         old    <= 1'b0;
      end else begin
         slot_v <= nxt_v;
         old    <= old_nxt;
         if (|gnt) pri <= gnt[REQ_ALU];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (acc[i]) begin
            slot_ad[i] <= in_ad[i];
            slot_d[i]  <= in_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we  <= 1'b0;
         wad <= '0;
         wd  <= '0;
      end else begin
         we <= |gnt;
         if (|gnt) begin
            wad <= slot_ad[gk];
            wd  <= slot_d[gk];
         end
      end
   end

   always_comb begin
      pend = '0;
      for (int r = 0; r < NREG; r++) begin
         if ((slot_v[0] && slot_ad[0] == AW'(r)) ||
             (slot_v[1] && slot_ad[1] == AW'(r)) ||
             (we && wad == AW'(r)))
            pend[r] = 1'b1;
      end
   end

endmodule

// File: tb/tb_rega_wrarb.sv
// Scoreboard bench for rega_wrarb: a timestamp-based reference model predicts
// every array write; an independent monitor checks what the DUT emits.
module tb_rega_wrarb;
   import pu_pkg::*;

   typedef struct {
      wreq_t w;
      int    cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             v0 = 1'b0, v1 = 1'b0;
   logic [RASB:0]    ad0 = '0, ad1 = '0;
   logic [WIDTH:0]   d0 = '0, d1 = '0;
   logic             rdy0, rdy1, we;
   logic [RASB:0]    wad;
   logic [WIDTH:0]   wd;
   logic [NREG-1:0]  pend;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wcount = 0;
   int w3cnt = 0;
   exp_t exp_q[$];

   bit              m_v[2];
   logic [RASB:0]   m_ad[2];
   logic [WIDTH:0]  m_d[2];
   int              m_stamp[2];
   int              last_gnt = 1;
   bit              out_we = 1'b0;
   logic [RASB:0]   out_ad = '0;
   logic [WIDTH:0]  obs_mem[NREG];

   rega_wrarb dut (
      .clk  (clk),
      .rst  (rst),
      .v0   (v0),
      .rdy0 (rdy0),
      .ad0  (ad0),
      .d0   (d0),
      .v1   (v1),
      .rdy1 (rdy1),
      .ad1  (ad1),
      .d1   (d1),
      .we   (we),
      .wad  (wad),
      .wd   (wd),
      .pend (pend)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Oldest-by-timestamp wins a same-register conflict; otherwise the
   // requester that did not win last time is favoured.
   function automatic int model_grant();
      if (m_v[0] && m_v[1]) begin
         if (m_ad[0] == m_ad[1]) return (m_stamp[1] < m_stamp[0]) ? 1 : 0;
         return (last_gnt == 0) ? 1 : 0;
      end
      if (m_v[0]) return 0;
      if (m_v[1]) return 1;
      return -1;
   endfunction

   function automatic logic [NREG-1:0] model_pend();
      logic [NREG-1:0] p = '0;
      for (int r = 0; r < NREG; r++) begin
         for (int i = 0; i < 2; i++)
            if (m_v[i] && int'(m_ad[i]) == r) p[r] = 1'b1;
         if (out_we && int'(out_ad) == r) p[r] = 1'b1;
      end
      return p;
   endfunction

   task automatic model_reset();
      m_v[0] = 1'b0;
      m_v[1] = 1'b0;
      last_gnt = 1;
      out_we = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step(input int k);
      bit             vin[2];
      logic [RASB:0]  ain[2];
      logic [WIDTH:0] din[2];
      bit             rdy_m[2];
      exp_t           e;
      vin = '{v0, v1};
      ain = '{ad0, ad1};
      din = '{d0, d1};
      for (int i = 0; i < 2; i++) rdy_m[i] = !m_v[i] || (k == i);
      if (k >= 0) begin
         e.w.ad = m_ad[k];
         e.w.d  = m_d[k];
         e.cyc  = cyc + 1;
         exp_q.push_back(e);
         m_v[k]   = 1'b0;
         last_gnt = k;
         out_we   = 1'b1;
         out_ad   = m_ad[k];
      end else begin
         out_we = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         if (vin[i] && rdy_m[i]) begin
            m_v[i]     = 1'b1;
            m_ad[i]    = ain[i];
            m_d[i]     = din[i];
            m_stamp[i] = cyc;
         end
      end
   endtask

   task automatic apply_stimulus(input bit a_v0, input logic [RASB:0] a_ad0, input logic [WIDTH:0] a_d0,
                                 input bit a_v1, input logic [RASB:0] a_ad1, input logic [WIDTH:0] a_d1);
      int k;
      @(negedge clk);
      v0 = a_v0; ad0 = a_ad0; d0 = a_d0;
      v1 = a_v1; ad1 = a_ad1; d1 = a_d1;
      k = model_grant();
      check_output("rdy0", rdy0, (!m_v[0] || k == 0));
      check_output("rdy1", rdy1, (!m_v[1] || k == 1));
      check_output("pend", pend, model_pend());
      model_step(k);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b1;
      v0 = 1'b0;
      v1 = 1'b0;
      check_output("rdy0_release", rdy0, 1);
      check_output("rdy1_release", rdy1, 1);
      model_step(model_grant());
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      model_reset();
      #1;
      check_output("rst_we", we, 0);
      check_output("rst_wad", wad, 0);
      check_output("rst_wd", wd, 0);
      check_output("rst_pend", pend, 0);
      check_output("rst_rdy0", rdy0, 1);
      check_output("rst_rdy1", rdy1, 1);
      release_reset();
   endtask

   // Monitor: every DUT write must match the head of the expected queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_write: got wad=%0h wd=%0h expected no write (cycle %0d)", wad, wd, cyc);
            end else begin
               e = exp_q.pop_front();
               check_output("write_data", {14'b0, wad, wd}, {14'b0, e.w.ad, e.w.d});
               check_output("write_cycle", cyc, e.cyc);
            end
            obs_mem[wad] = wd;
            wcount++;
            if (wad == 2'd3) w3cnt++;
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_write: got we=%0b expected write wad=%0h wd=%0h (cycle %0d)", we, e.w.ad, e.w.d, cyc);
         end
      end
   end

   initial begin
      int w0;
      int w3;
      for (int r = 0; r < NREG; r++) obs_mem[r] = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_output("init_we", we, 0);
      check_output("init_pend", pend, 0);
      check_output("init_rdy0", rdy0, 1);
      check_output("init_rdy1", rdy1, 1);
      release_reset();

      apply_stimulus(1'b1, 2'd2, 16'h1234, 1'b0, '0, '0);
      idle(3);
      check_output("single_r2", obs_mem[2], 16'h1234);

      for (int i = 0; i < 10; i++)
         apply_stimulus(1'b1, 2'd1, 16'h1000 + 16'(i), 1'b1, 2'd3, 16'h2000 + 16'(i));
      apply_reset();

      apply_stimulus(1'b1, 2'd1, 16'h1111, 1'b1, 2'd2, 16'hAAAA);
      apply_stimulus(1'b1, 2'd2, 16'hBBBB, 1'b0, '0, '0);
      idle(4);
      check_output("waw_r2", obs_mem[2], 16'hBBBB);

      apply_reset();
      apply_stimulus(1'b1, 2'd2, 16'hCCCC, 1'b1, 2'd2, 16'hDDDD);
      idle(4);
      check_output("waw_same_edge_r2", obs_mem[2], 16'hDDDD);

      w0 = wcount;
      for (int i = 0; i < 8; i++)
         apply_stimulus(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 1'b0, '0, '0);
      idle(3);
      check_output("stream_writes", wcount - w0, 8);

      w3 = w3cnt;
      apply_stimulus(1'b1, 2'd3, 16'h3333, 1'b0, '0, '0);
      apply_reset();
      idle(3);
      check_output("rst_mid_no_r3", w3cnt - w3, 0);
      apply_stimulus(1'b1, 2'd1, 16'h5555, 1'b0, '0, '0);
      idle(2);
      check_output("resume_r1", obs_mem[1], 16'h5555);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 79) == 0) apply_reset();
         else apply_stimulus($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), 16'($urandom),
                             $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), 16'($urandom));
      end
      idle(4);
      check_output("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
